// File: rtl/iob_native_mem_resp.sv
// IOb native responder: serves requests from an internal word-organised RAM, flags out-of-range accesses.
// Latency: WAIT_STATES cycles before ready_o, then read data READ_LAT cycles after acceptance.
// Backpressure: ready_o gates acceptance (depends only on FSM state and cke_i); rvalid_o is never stalled.
//
// Ports:
//   clk_i, rst_n_i (async active-low), cke_i (clock enable, low freezes all state)
//   avalid_i, addr_i, wdata_i, wstrb_i  request side (wstrb_i == 0 means read)
//   ready_o                             acceptance strobe
//   rvalid_o, rdata_o                   read response pulse and data
//   err_o                               sticky out-of-range flag, cleared only by reset
module iob_native_mem_resp #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_STATES = 0,
  parameter int READ_LAT    = 1,
  localparam int WSTRB_W    = DATA_W / 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cke_i,
  input  logic               avalid_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [WSTRB_W-1:0] wstrb_i,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               rvalid_o,
  output logic               ready_o,
  output logic               err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACC
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

  logic [MEM_ADDR_W-1:0] word_idx;
  logic                  in_range;
  logic                  is_write;
  logic                  accept;

  // Read pipeline: stage 0 is loaded at acceptance, last stage drives the outputs.
  logic [READ_LAT-1:0] vld_q;
  logic [DATA_W-1:0]   dat_q [READ_LAT];

  assign word_idx = addr_i[MEM_ADDR_W+1:2];
  // Any set bit above the RAM window makes the access out of range (no aliasing).
  assign in_range = (addr_i >> (MEM_ADDR_W + 2)) == '0;
  assign is_write = |wstrb_i;

  // Kept free of avalid_i so an initiator may derive avalid from ready without a loop.
  assign ready_o = (WAIT_STATES == 0) ? cke_i : (cke_i && (state_q == S_ACC));
  assign accept  = avalid_i && ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (WAIT_STATES != 0) begin
      case (state_q)
        S_IDLE: begin
          if (avalid_i) begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = (WAIT_STATES == 1) ? S_ACC : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!avalid_i) begin
            // Initiator withdrew: drop the request, next one pays full wait states.
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_ACC;
          end
        end
        S_ACC:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_o   <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && !in_range) err_o <= 1'b1;
      vld_q[0] <= accept && !is_write;
      if (accept && !is_write) dat_q[0] <= in_range ? mem[word_idx] : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // RAM contents survive reset; writes are blocked while reset is held.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && accept && is_write && in_range) begin
      for (int b = 0; b < WSTRB_W; b++) begin
        if (wstrb_i[b]) mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rvalid_o = vld_q[READ_LAT-1];
  assign rdata_o  = dat_q[READ_LAT-1];

endmodule
